// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and pipeline-register layouts for the memory stage.
// Status codes, instruction codes, register IDs and the bubble values for M and W.
package y86_pkg;

  localparam logic [3:0] SAOK  = 4'h1;
  localparam logic [3:0] SHLT  = 4'h2;
  localparam logic [3:0] SADR  = 4'h3;
  localparam logic [3:0] SINS  = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat: SAOK, icode: 4'h1, cnd: 1'b0,
    val_e: 64'd0, val_a: 64'd0, dst_e: RNONE, dst_m: RNONE
  };

  localparam w_reg_t W_BUBBLE = '{
    stat: SAOK, icode: 4'h1,
    val_e: 64'd0, val_m: 64'd0, dst_e: RNONE, dst_m: RNONE
  };

endpackage

// File: rtl/memory_stage_data_mem.sv
// Byte-addressed little-endian data memory: combinational 64-bit read, clocked 64-bit write.
// Optional MEM_ALIGN_CHECK_EN makes any access with addr[2:0]!=0 an address error.
module data_mem #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [63:0]       i_wdata,
  input  logic              i_stat_ok,
  output logic [63:0]       o_rdata,
  output logic              o_dmem_error
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  logic [7:0]        r_mem [0:MEM_BYTES-1];
  logic [ADDR_W:0]   w_last;
  logic              w_in_range;
  logic              w_misaligned;
  logic              w_valid;
  logic              w_we;
  logic [IDX_W-1:0]  w_idx;
  logic [63:0]       w_rword;

  // One extra bit so an address near 2^ADDR_W cannot wrap into range.
  assign w_last     = {1'b0, i_addr} + (ADDR_W+1)'(7);
  assign w_in_range = w_last < (ADDR_W+1)'(MEM_BYTES);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (i_addr[2:0] != 3'b000);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_valid      = w_in_range & ~w_misaligned;
  assign o_dmem_error = (i_read | i_write) & ~w_valid;
  assign w_we         = i_write & w_valid & i_stat_ok & rst_n;
  assign w_idx        = i_addr[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rd_byte
      assign w_rword[8*gi +: 8] = r_mem[w_idx + IDX_W'(gi)];
    end
  endgenerate

  assign o_rdata = (i_read & w_valid) ? w_rword : 64'd0;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_idx + IDX_W'(i)] <= i_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data-memory access, W pipeline register.
// Optional MEM_ALIGN_CHECK_EN (passed to data_mem) flags unaligned accesses as SADR.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_bubble,
  input  logic        W_stall,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  m_reg_t            r_m;
  w_reg_t            r_w;
  logic              w_read;
  logic              w_write;
  logic [63:0]       w_addr_full;
  logic              w_dmem_error;
  logic [63:0]       w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= M_BUBBLE;
    end else if (M_bubble) begin
      r_m <= M_BUBBLE;
    end else begin
      r_m <= '{stat: e_stat, icode: e_icode, cnd: e_cnd, val_e: e_valE,
               val_a: e_valA, dst_e: e_dstE, dst_m: e_dstM};
    end
  end

  always_comb begin
    w_read      = 1'b0;
    w_write     = 1'b0;
    w_addr_full = r_m.val_e;
    case (r_m.icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: w_write = 1'b1;
      I_MRMOVQ:                  w_read  = 1'b1;
      I_RET, I_POPQ: begin
        w_read      = 1'b1;
        w_addr_full = r_m.val_a;
      end
      default: ;
    endcase
  end

  data_mem #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_data_mem (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (w_read),
    .i_write      (w_write),
    .i_addr       (w_addr_full[ADDR_W-1:0]),
    .i_wdata      (r_m.val_a),
    .i_stat_ok    (r_m.stat == SAOK),
    .o_rdata      (w_rdata),
    .o_dmem_error (w_dmem_error)
  );

  assign m_stat = w_dmem_error ? SADR : r_m.stat;
  assign m_valM = w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= W_BUBBLE;
    end else if (!W_stall) begin
      r_w <= '{stat: m_stat, icode: r_m.icode, val_e: r_m.val_e,
               val_m: m_valM, dst_e: r_m.dst_e, dst_m: r_m.dst_m};
    end
  end

  assign M_stat  = r_m.stat;
  assign M_icode = r_m.icode;
  assign M_cnd   = r_m.cnd;
  assign M_valE  = r_m.val_e;
  assign M_valA  = r_m.val_a;
  assign M_dstE  = r_m.dst_e;
  assign M_dstM  = r_m.dst_m;

  assign W_stat  = r_w.stat;
  assign W_icode = r_w.icode;
  assign W_valE  = r_w.val_e;
  assign W_valM  = r_w.val_m;
  assign W_dstE  = r_w.dst_e;
  assign W_dstM  = r_w.dst_m;

endmodule
